demux_1x2_8bit_stream: RTL and testbench
========================================

// Module: demux_1x2_8bit_stream
// PURPOSE
//  Streaming 1-to-2 byte demultiplexer: the distributing counterpart of the 2:1 byte mux.
//  Accepts one byte per cycle on a valid/ready input and routes it by in_sel to output A (sel=0)
//  or output B (sel=1). Each output is decoupled by its own small FIFO, so a stalled consumer
//  blocks only traffic addressed to it. Sits between a byte producer (e.g. the store/UART path)
//  and two byte consumers.
// PARAMETERS
//  WIDTH  8  data width in bits
//  DEPTH  2  entries per output FIFO; power of two, >= 2
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst          in   1      synchronous reset, active-high
//  in_valid     in   1      input byte present
//  in_ready     out  1      input byte accepted this cycle when in_valid & in_ready
//  in_sel       in   1      destination: 0 -> A, 1 -> B; stable while in_valid & !in_ready
//  in_data      in   WIDTH  input byte
//  a_valid      out  1      output A has a byte
//  a_ready      in   1      consumer A takes the byte when a_valid & a_ready
//  a_data       out  WIDTH  output A byte (head of FIFO A)
//  b_valid      out  1      as a_valid, for output B
//  b_ready      in   1      as a_ready, for output B
//  b_data       out  WIDTH  as a_data, for output B
//  a_count      out  $clog2(DEPTH)+1  occupancy of FIFO A
//  b_count      out  $clog2(DEPTH)+1  occupancy of FIFO B
// BEHAVIOUR
//  - One clock (clk), synchronous active-high reset (rst). During and after reset: both FIFOs empty,
//    a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0, read/write pointers=0.
//  - in_ready = in_sel ? !full_B : !full_A. Depends only on in_sel and registered state;
//    no combinational path from a_ready/b_ready to in_ready.
//  - Push: in_valid & in_ready writes in_data into the selected FIFO at its write pointer;
//    the unselected FIFO is untouched.
//  - Pop: x_valid & x_ready advances that FIFO's read pointer.
//  - Latency: a byte accepted in cycle N is visible on x_valid/x_data in cycle N+1 at the earliest
//    (no same-cycle bypass).
//  - Per-output order preserved; no ordering guarantee between A and B.
//  - x_valid = (x_count != 0); x_data = mem[rd_ptr] (registered storage, mux on read pointer).
//  - Counts: count_next = count + push - pop; simultaneous push & pop leaves count unchanged
//    and moves both pointers.
//  - Full FIFO: in_ready=0 for that destination even if its consumer pops in the same cycle;
//    the pop frees the slot, so in_ready=1 next cycle. The other destination stays acceptable.
//  - Empty FIFO: a pop is impossible (x_valid=0); x_ready is ignored.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no bubble.
//  - in_sel change while in_valid & !in_ready: protocol violation, checked by an assertion;
//    the RTL evaluates the new in_sel.
//  - Reset mid-stream: all buffered bytes are discarded; the outputs hold the reset values
//    in the next cycle.
//  - Throughput: 1 byte/cycle per destination when that consumer holds ready=1 (DEPTH>=2).
// STRUCTURE
//  - Package demux_pkg: localparam DEMUX_WIDTH=8, DEMUX_DEPTH=2;
//    typedef enum logic {DEST_A=1'b0, DEST_B=1'b1} dest_e; typedef logic [7:0] byte_t.
//  - Sub-module sync_fifo_8bit (WIDTH, DEPTH; push/pop/full/empty/count/dout), instantiated
//    twice (A, B).
//  - Top level: in_sel decode to push_a/push_b, in_ready mux, output wiring.
// TESTING
//  1 Reset: assert rst for 3 cycles with in_valid=1 -> a_valid=b_valid=0, counts=0, no push
//    occurs; release -> in_ready=1.
//  2 Routing: a_ready=b_ready=1; send 0x11(sel0), 0x22(sel1), 0x33(sel0) back-to-back ->
//    A sees 0x11,0x33 and B sees 0x22, each 1 cycle after acceptance.
//  3 Full/backpressure: a_ready=0; push 0xA0,0xA1 to A -> a_count=2; in_ready=0 for sel0;
//    sel1 byte 0xB0 is still accepted; set a_ready=1 -> A outputs 0xA0,0xA1 and accepts again
//    the cycle after the first pop.
//  4 Simultaneous push/pop at count=1: a_ready=1 and push to A each cycle for 8 cycles ->
//    a_count stays 1; pointers wrap; data order 0..7 intact.
//  5 Reset mid-operation: A holds 2 bytes, B holds 1; pulse rst 1 cycle -> next cycle all
//    valids=0 and counts=0; a new byte 0x5A to B appears alone on B.
//  6 Random soak: 10k cycles, random valid/sel/ready -> scoreboard per-output order matches;
//    no byte lost or duplicated.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1-to-2 streaming byte demultiplexer.
package demux_pkg;

  localparam int DEMUX_WIDTH = 8;
  localparam int DEMUX_DEPTH = 2;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/sync_fifo_8bit.sv
// Small synchronous FIFO with registered storage; dout is the head entry, muxed by the read pointer.
module sync_fifo_8bit
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guarding here keeps the FIFO safe even if a caller ignores full/empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/demux_1x2_8bit_stream.sv
// Streaming 1-to-2 byte demultiplexer: routes each accepted byte by in_sel into per-output FIFOs.
module demux_1x2_8bit_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int DEPTH = DEMUX_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  dest_e dest;
  logic  full_a;
  logic  full_b;
  logic  empty_a;
  logic  empty_b;
  logic  push_a;
  logic  push_b;
  logic  pop_a;
  logic  pop_b;

  assign dest = dest_e'(in_sel);

  // Readiness looks only at registered fullness, never at the consumers' ready.
  assign in_ready = (dest == DEST_B) ? !full_b : !full_a;

  assign push_a = in_valid && in_ready && (dest == DEST_A);
  assign push_b = in_valid && in_ready && (dest == DEST_B);
  assign pop_a  = a_valid && a_ready;
  assign pop_b  = b_valid && b_ready;

  assign a_valid = !empty_a;
  assign b_valid = !empty_b;

  sync_fifo_8bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .din   (in_data),
    .pop   (pop_a),
    .full  (full_a),
    .empty (empty_a),
    .count (a_count),
    .dout  (a_data)
  );

  sync_fifo_8bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .din   (in_data),
    .pop   (pop_b),
    .full  (full_b),
    .empty (empty_b),
    .count (b_count),
    .dout  (b_data)
  );

  // A stalled producer must not retarget its byte while still offering it.
  sel_stable_while_stalled: assert property (
    @(posedge clk) disable iff (rst)
      (in_valid && !in_ready) |=> (!in_valid || $stable(in_sel))
  );

endmodule

// File: tb/tb_demux_1x2_8bit_stream.sv
// Directed and soak checks for demux_1x2_8bit_stream with immediate assertions and a queue scoreboard.
module tb_demux_1x2_8bit_stream;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic [7:0] in_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_data;
  logic [1:0] a_count;
  logic [1:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;

  byte_t qa[$];
  byte_t qb[$];

  always #5 clk = ~clk;

  demux_1x2_8bit_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic       hold;
    logic       exp_ready;
    logic       pop_a_m;
    logic       pop_b_m;
    logic       push_m;

    // Reset held with a byte offered: nothing may be stored.
    rst = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 8'hFF);
    repeat (3) tick();
    check_output("rst_a_valid", a_valid, 0);
    check_output("rst_b_valid", b_valid, 0);
    check_output("rst_a_count", a_count, 0);
    check_output("rst_b_count", b_count, 0);
    check_output("rst_a_data", a_data, 0);
    check_output("rst_b_data", b_data, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    check_output("rel_in_ready", in_ready, 1);

    // Routing, back-to-back, both consumers ready.
    a_ready = 1'b1; b_ready = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'h11);
    check_output("rt_ready0", in_ready, 1);
    tick();
    check_output("rt_a_valid1", a_valid, 1);
    check_output("rt_a_data1", a_data, 8'h11);
    check_output("rt_b_valid1", b_valid, 0);
    apply_stimulus(1'b1, 1'b1, 8'h22);
    tick();
    check_output("rt_b_valid2", b_valid, 1);
    check_output("rt_b_data2", b_data, 8'h22);
    check_output("rt_a_valid2", a_valid, 0);
    apply_stimulus(1'b1, 1'b0, 8'h33);
    tick();
    check_output("rt_a_valid3", a_valid, 1);
    check_output("rt_a_data3", a_data, 8'h33);
    check_output("rt_b_valid3", b_valid, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    tick();
    check_output("rt_a_valid4", a_valid, 0);

    // Fill A, confirm B still flows, then drain A.
    a_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 8'hA0);
    tick();
    check_output("fu_a_count1", a_count, 1);
    apply_stimulus(1'b1, 1'b0, 8'hA1);
    tick();
    check_output("fu_a_count2", a_count, 2);
    check_output("fu_a_head", a_data, 8'hA0);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("fu_ready_a_full", in_ready, 0);
    apply_stimulus(1'b1, 1'b1, 8'hB0);
    check_output("fu_ready_b", in_ready, 1);
    tick();
    check_output("fu_b_valid", b_valid, 1);
    check_output("fu_b_data", b_data, 8'hB0);
    check_output("fu_a_count_hold", a_count, 2);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    a_ready = 1'b1;
    #1;
    check_output("fu_ready_pop_same", in_ready, 0);
    tick();
    check_output("fu_a_data2", a_data, 8'hA1);
    check_output("fu_a_count3", a_count, 1);
    check_output("fu_ready_after_pop", in_ready, 1);
    check_output("fu_b_drained", b_valid, 0);
    tick();
    check_output("fu_a_empty", a_valid, 0);
    check_output("fu_a_count0", a_count, 0);

    // Steady push+pop at count 1; pointers wrap several times.
    apply_stimulus(1'b1, 1'b0, 8'h00);
    tick();
    check_output("pp_data0", a_data, 0);
    for (int i = 1; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'(i));
      tick();
      check_output($sformatf("pp_count%0d", i), a_count, 1);
      check_output($sformatf("pp_data%0d", i), a_data, i);
    end
    apply_stimulus(1'b0, 1'b0, 8'h00);
    tick();
    check_output("pp_drained", a_count, 0);

    // Reset with bytes buffered in both FIFOs.
    a_ready = 1'b0; b_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 8'h01);
    tick();
    apply_stimulus(1'b1, 1'b0, 8'h02);
    tick();
    apply_stimulus(1'b1, 1'b1, 8'h03);
    tick();
    check_output("mr_a_count", a_count, 2);
    check_output("mr_b_count", b_count, 1);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mr_a_valid", a_valid, 0);
    check_output("mr_b_valid", b_valid, 0);
    check_output("mr_a_count0", a_count, 0);
    check_output("mr_b_count0", b_count, 0);
    check_output("mr_a_data0", a_data, 0);
    apply_stimulus(1'b1, 1'b1, 8'h5A);
    tick();
    check_output("mr_b_new_valid", b_valid, 1);
    check_output("mr_b_new_data", b_data, 8'h5A);
    check_output("mr_a_alone", a_valid, 0);
    check_output("mr_b_count1", b_count, 1);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    b_ready = 1'b1;
    tick();
    check_output("mr_b_drained", b_valid, 0);

    // Random soak against a queue model; a stalled offer is held unchanged.
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      #1;
      exp_ready = in_sel ? (qb.size() < 2) : (qa.size() < 2);
      check_output("sk_in_ready", in_ready, exp_ready);
      check_output("sk_a_valid", a_valid, qa.size() != 0);
      check_output("sk_b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) check_output("sk_a_data", a_data, qa[0]);
      if (qb.size() != 0) check_output("sk_b_data", b_data, qb[0]);
      pop_a_m = (qa.size() != 0) && a_ready;
      pop_b_m = (qb.size() != 0) && b_ready;
      push_m  = in_valid && exp_ready;
      if (pop_a_m) void'(qa.pop_front());
      if (pop_b_m) void'(qb.pop_front());
      if (push_m) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
      hold = in_valid && !exp_ready;
      tick();
    end
    check_output("sk_a_count_end", a_count, qa.size());
    check_output("sk_b_count_end", b_count, qb.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
